// File: rtl/sw_response_decoder.sv
// sw_response_decoder
// Reads the 16 slide switches of the reflex game, synchronises and debounces
// them, and reports each debounced toggle to the game controller.
// A report carries the index of the switch that changed, whether that switch
// matches the lit LED (target), and whether several switches moved together.
// Reports are held until the controller acknowledges them with hit_ack.
// Optional feature: define MISS_CNT_EN to add the miss_count output, a
// saturating count of wrong responses that clears when arm rises.
module sw_response_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [15:0] target,
  input  logic        arm,
  input  logic        hit_ack,
  output logic        hit_valid,
  output logic [3:0]  hit_idx,
  output logic        hit_correct,
  output logic        multi_err
`ifdef MISS_CNT_EN
  ,
  output logic [7:0]  miss_count
`endif
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPORT
  } stateT;

  stateT       state;
  stateT       nextState;

  logic [15:0] swMeta;
  logic [15:0] swSync;
  logic [CNT_W-1:0] tickCnt;
  logic        tick;
  logic [15:0] samp;
  logic [15:0] stable;
  logic [15:0] stableD;
  logic [15:0] agree;
  logic        initDone;
  logic [15:0] chg;
  logic [3:0]  lowIdx;
  logic        multiHit;
  logic        captureEn;
  logic        ackEn;

  // Two-flop synchroniser: the switches are asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= sw;
      swSync <= swMeta;
    end
  end

  // Free-running sample counter; tick marks the last count of each period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tickCnt <= '0;
    end else if (tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + CNT_W'(1);
    end
  end

  assign tick  = (tickCnt == TICK_LAST);
  assign agree = ~(swSync ^ samp);

  // Debounce: a bit of stable follows swSync only when two consecutive ticks
  // see the same value; the first tick after reset loads the power-up
  // positions into both stable and stableD so they never look like a toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp     <= '0;
      stable   <= '0;
      stableD  <= '0;
      initDone <= 1'b0;
    end else begin
      stableD <= stable;
      if (tick) begin
        samp <= swSync;
        if (!initDone) begin
          stable   <= swSync;
          stableD  <= swSync;
          initDone <= 1'b1;
        end else begin
          stable <= (stable & ~agree) | (swSync & agree);
        end
      end
    end
  end

  assign chg      = stable ^ stableD;
  assign multiHit = |(chg & (chg - 16'd1));

  // Priority encoder: lowest changed switch wins when several move together.
  always_comb begin
    lowIdx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (chg[i]) begin
        lowIdx = 4'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state; arm low beats a same-cycle change, reports wait for ack.
  always_comb begin
    nextState = state;
    captureEn = 1'b0;
    ackEn     = 1'b0;
    case (state)
      IDLE: begin
        if (arm && initDone) begin
          nextState = ARMED;
        end
      end
      ARMED: begin
        if (!arm) begin
          nextState = IDLE;
        end else if (chg != 16'd0) begin
          captureEn = 1'b1;
          nextState = REPORT;
        end
      end
      REPORT: begin
        if (hit_ack) begin
          ackEn     = 1'b1;
          nextState = arm ? ARMED : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Report registers: loaded on capture, judgement flags dropped on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_idx     <= '0;
      hit_correct <= 1'b0;
      multi_err   <= 1'b0;
    end else if (captureEn) begin
      hit_idx     <= lowIdx;
      hit_correct <= target[lowIdx];
      multi_err   <= multiHit;
    end else if (ackEn) begin
      hit_correct <= 1'b0;
      multi_err   <= 1'b0;
    end
  end

  assign hit_valid = (state == REPORT);

`ifdef MISS_CNT_EN
  logic       armPrev;
  logic [7:0] missCnt;

  // Saturating wrong-response counter, restarted at the start of each round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armPrev <= 1'b0;
      missCnt <= '0;
    end else begin
      armPrev <= arm;
      if (arm && !armPrev) begin
        missCnt <= '0;
      end else if (captureEn && !target[lowIdx] && (missCnt != 8'hFF)) begin
        missCnt <= missCnt + 8'd1;
      end
    end
  end

  assign miss_count = missCnt;
`endif

endmodule

// File: tb/tb_sw_response_decoder.sv
// tb_sw_response_decoder
// Self-checking bench for sw_response_decoder with DEBOUNCE_CYCLES=4.
// A behavioural model tracks the switch path and the report handshake; a
// compare process checks the DUT against it on every negedge. Directed
// scenarios add literal expectations, then a randomized phase follows.
module tb_sw_response_decoder;

  localparam int DEB      = 4;
  localparam int M_IDLE   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_REPORT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = 16'h0081;
  logic [15:0] target = 16'h0000;
  logic        arm = 1'b0;
  logic        hit_ack = 1'b0;
  logic        hit_valid;
  logic [3:0]  hit_idx;
  logic        hit_correct;
  logic        multi_err;
`ifdef MISS_CNT_EN
  logic [7:0]  miss_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  sw_response_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .target(target),
    .arm(arm),
    .hit_ack(hit_ack),
    .hit_valid(hit_valid),
    .hit_idx(hit_idx),
    .hit_correct(hit_correct),
    .multi_err(multi_err)
`ifdef MISS_CNT_EN
    ,
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model state: what the switch path and report must look like.
  int          mCyc;
  logic [15:0] mS1, mS2, mSamp, mStable, mStableD;
  logic        mInit;
  int          mMode;
  logic [3:0]  mIdx;
  logic        mCorrect, mMulti;
  int          mMiss;
  logic        mArmPrev;

  task automatic modelReset();
    mCyc = 0; mS1 = '0; mS2 = '0; mSamp = '0; mStable = '0; mStableD = '0;
    mInit = 1'b0; mMode = M_IDLE; mIdx = '0; mCorrect = 1'b0; mMulti = 1'b0;
    mMiss = 0; mArmPrev = 1'b0;
  endtask

  task automatic modelStep();
    logic        tickM;
    logic [15:0] chgM, nextStable, nextStableD;
    int          first;
    tickM = (mCyc == DEB - 1);
    chgM  = mStable ^ mStableD;
    case (mMode)
      M_IDLE:   if (arm && mInit) mMode = M_ARMED;
      M_ARMED: begin
        if (!arm) begin
          mMode = M_IDLE;
        end else if (chgM != 16'd0) begin
          first = -1;
          for (int i = 0; i < 16; i++) if (chgM[i] && first < 0) first = i;
          mIdx     = 4'(first);
          mCorrect = target[first];
          mMulti   = ($countones(chgM) > 1);
          mMode    = M_REPORT;
          if (!mCorrect && mMiss < 255) mMiss++;
        end
      end
      M_REPORT: begin
        if (hit_ack) begin
          mCorrect = 1'b0;
          mMulti   = 1'b0;
          mMode    = arm ? M_ARMED : M_IDLE;
        end
      end
      default: mMode = M_IDLE;
    endcase
    if (arm && !mArmPrev) mMiss = 0;
    mArmPrev = arm;
    nextStable  = mStable;
    nextStableD = mStable;
    if (tickM) begin
      if (!mInit) begin
        nextStable  = mS2;
        nextStableD = mS2;
        mInit       = 1'b1;
      end else begin
        for (int b = 0; b < 16; b++) if (mS2[b] == mSamp[b]) nextStable[b] = mS2[b];
      end
      mSamp = mS2;
    end
    mStable  = nextStable;
    mStableD = nextStableD;
    mS2 = mS1;
    mS1 = sw;
    mCyc = tickM ? 0 : mCyc + 1;
  endtask

  // Model advances on each clock edge and resets asynchronously with rst.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) modelReset();
      else modelStep();
    end
  end

  // Per-cycle comparison of the DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("cyc_hit_valid", int'(hit_valid), int'(mMode == M_REPORT));
        checkOutput("cyc_hit_idx", int'(hit_idx), int'(mIdx));
        checkOutput("cyc_hit_correct", int'(hit_correct), int'(mCorrect));
        checkOutput("cyc_multi_err", int'(multi_err), int'(mMulti));
`ifdef MISS_CNT_EN
        checkOutput("cyc_miss_count", int'(miss_count), mMiss);
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] s, input logic a, input logic [15:0] t, input logic k);
    @(negedge clk);
    sw = s; arm = a; target = t; hit_ack = k;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input int maxCycles, output int seenAt);
    seenAt = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (hit_valid) begin
        seenAt = i;
        break;
      end
    end
  endtask

  task automatic countValid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (hit_valid) cnt++;
    end
  endtask

  task automatic ackPulse();
    applyStimulus(sw, arm, target, 1'b1);
    applyStimulus(sw, arm, target, 1'b0);
  endtask

  task automatic toggleAndCheck(input string name, input logic [15:0] s, input int expIdx,
                                input int expCorrect, input int expMulti);
    int seenAt;
    applyStimulus(s, arm, target, 1'b0);
    waitValid(11, seenAt);
    checkOutput({name, "_seen"}, int'(seenAt > 0), 1);
    checkOutput({name, "_idx"}, int'(hit_idx), expIdx);
    checkOutput({name, "_correct"}, int'(hit_correct), expCorrect);
    checkOutput({name, "_multi"}, int'(multi_err), expMulti);
  endtask

  initial begin
    int cnt;
    logic [15:0] s;
    logic [15:0] m;

    // Scenario 1: reset with 0081 on the switches, no power-up event.
    #1 rst = 1'b0;
    waitCycles(2);
    checkOutput("rst_hit_valid", int'(hit_valid), 0);
    checkOutput("rst_hit_idx", int'(hit_idx), 0);
    checkOutput("rst_hit_correct", int'(hit_correct), 0);
    checkOutput("rst_multi_err", int'(multi_err), 0);
    rst = 1'b1;
    applyStimulus(16'h0081, 1'b1, 16'h0000, 1'b0);
    countValid(50, cnt);
    checkOutput("s1_no_powerup_event", cnt, 0);

    // Scenario 2: correct single toggle, then acknowledge.
    applyStimulus(16'h0081, 1'b1, 16'h0020, 1'b0);
    toggleAndCheck("s2", 16'h00A1, 5, 1, 0);
    checkOutput("s2_model_idx", int'(mIdx), 5);
    ackPulse();
    checkOutput("s2_valid_cleared", int'(hit_valid), 0);
    checkOutput("s2_correct_cleared", int'(hit_correct), 0);

    // Scenario 3: bits 3 and 9 together.
    toggleAndCheck("s3", 16'h02A9, 3, 0, 1);
    checkOutput("s3_model_multi", int'(mMulti), 1);
    ackPulse();

    // Scenario 4: 2-cycle glitch on bit 7, then a real toggle on bit 2.
    applyStimulus(16'h0229, 1'b1, 16'h0020, 1'b0);
    waitCycles(1);
    applyStimulus(16'h02A9, 1'b1, 16'h0020, 1'b0);
    countValid(16, cnt);
    checkOutput("s4_glitch_ignored", cnt, 0);
    toggleAndCheck("s4", 16'h02AD, 2, 0, 0);
    ackPulse();

    // Scenario 5: toggle and drop arm while a report is pending.
    toggleAndCheck("s5", 16'h02AF, 1, 0, 0);
    applyStimulus(16'h02BF, 1'b0, 16'h0020, 1'b0);
    waitCycles(14);
    checkOutput("s5_held_valid", int'(hit_valid), 1);
    checkOutput("s5_held_idx", int'(hit_idx), 1);
    ackPulse();
    checkOutput("s5_valid_cleared", int'(hit_valid), 0);
    applyStimulus(16'h02BF, 1'b1, 16'h0020, 1'b0);
    countValid(30, cnt);
    checkOutput("s5_dropped_toggle", cnt, 0);

    // Scenario 6: asynchronous reset in the middle of a report.
    toggleAndCheck("s6", 16'h02FF, 6, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("s6_async_valid", int'(hit_valid), 0);
    checkOutput("s6_async_idx", int'(hit_idx), 0);
    checkOutput("s6_async_correct", int'(hit_correct), 0);
    checkOutput("s6_async_multi", int'(multi_err), 0);
    waitCycles(2);
    rst = 1'b1;
    waitCycles(10);

`ifdef MISS_CNT_EN
    applyStimulus(16'h02FF, 1'b0, 16'h0000, 1'b0);
    applyStimulus(16'h02FF, 1'b1, 16'h0000, 1'b0);
    toggleAndCheck("mc1", 16'h06FF, 10, 0, 0);
    ackPulse();
    toggleAndCheck("mc2", 16'h0EFF, 11, 0, 0);
    ackPulse();
    toggleAndCheck("mc3", 16'h1EFF, 12, 0, 0);
    ackPulse();
    checkOutput("mc_three_misses", int'(miss_count), 3);
    applyStimulus(16'h1EFF, 1'b0, 16'h0000, 1'b0);
    applyStimulus(16'h1EFF, 1'b1, 16'h0000, 1'b0);
    waitCycles(2);
    checkOutput("mc_cleared_on_arm", int'(miss_count), 0);
`endif

    // Randomized phase: toggles, glitches, acks, arm and target changes.
    s = sw;
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: begin
          m = '0;
          m[$urandom_range(0, 15)] = 1'b1;
          if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 15)] = 1'b1;
          s = s ^ m;
          applyStimulus(s, arm, target, 1'b0);
          waitCycles($urandom_range(8, 16));
        end
        4: begin
          m = '0;
          m[$urandom_range(0, 15)] = 1'b1;
          applyStimulus(s ^ m, arm, target, 1'b0);
          waitCycles($urandom_range(0, 2));
          applyStimulus(s, arm, target, 1'b0);
        end
        5, 6: ackPulse();
        7: applyStimulus(s, ~arm, target, 1'b0);
        8: begin
          int v;
          v = $urandom_range(0, 16);
          m = '0;
          if (v < 16) m[v] = 1'b1;
          applyStimulus(s, arm, m, 1'b0);
        end
        default: waitCycles($urandom_range(1, 5));
      endcase
    end
    waitCycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sw_response_decoder.md
Name:
sw_response_decoder

Overview:
- Input-side counterpart to the LED/display path of the reflex game: reads the player's 16 slide switches and reports each response.
- Synchronises and debounces `sw`, then detects a toggle and encodes it to a 4-bit index.
- Judges each toggle against the one-hot `target` pattern currently driven on the LEDs.
- Presents the result to the game controller through a valid/ack handshake.

Parameters:
- DEBOUNCE_CYCLES, 1000000: clk cycles between debounce samples (10 ms at 100 MHz); legal range 2..2^CNT_W.
- CNT_W, 20: width of the sample-tick counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- sw  input  16  raw slide switches, asynchronous to clk
- target  input  16  one-hot lit-LED pattern for the current round (all-zero allowed)
- arm  input  1  round active; toggles are judged only while high
- hit_ack  input  1  controller has consumed the current report
- hit_valid  output  1  report pending
- hit_idx  output  4  index of the toggled switch
- hit_correct  output  1  target[hit_idx] at capture time
- multi_err  output  1  more than one switch changed in the captured event

Behaviour:
- Reset: one clock, asynchronous, active-low; polarity and synchronicity fixed. All registers clear on rst low, independent of clk. Outputs reset to hit_valid=0, hit_idx=0, hit_correct=0, multi_err=0. State resets to IDLE and init_done to 0.
- Synchroniser: 2-flop synchroniser per sw bit, giving sw_s.
- Sample tick:
  - Counter runs 0..DEBOUNCE_CYCLES-1 and wraps.
  - tick is high for one cycle when the counter equals DEBOUNCE_CYCLES-1.
- Debounce:
  - On each tick, samp <= sw_s.
  - A bit of `stable` updates only when sw_s equals samp on a tick, i.e. two consecutive ticks agree.
- Reset start-up:
  - On the first tick after reset, stable and stable_d load sw_s directly and init_done sets.
  - No event is generated for the power-up switch positions.
- Edge vector: chg = stable ^ stable_d. stable_d <= stable every cycle, so chg is a one-cycle pulse per debounced change.
- FSM:
  - IDLE: changes are absorbed and nothing is reported. Move to ARMED when arm=1 and init_done=1.
  - ARMED:
    - If arm=0, go to IDLE; arm low takes priority over a same-cycle chg.
    - Else if chg≠0, capture and go to REPORT.
  - Capture (registered on the same edge as the transition into REPORT):
    - hit_idx = lowest set bit of chg.
    - hit_correct = target[that bit].
    - multi_err = popcount(chg)>1.
    - hit_valid asserts on the following cycle, i.e. exactly 1 clk after chg.
  - REPORT:
    - hit_valid=1; hit_idx, hit_correct and multi_err are held stable.
    - Further chg pulses are dropped, not queued.
    - On hit_ack=1: hit_valid clears the next cycle, and multi_err and hit_correct clear. Next state is ARMED if arm=1, else IDLE.
    - arm falling while in REPORT does not cancel the report; the block waits for hit_ack.
- hit_ack outside REPORT: ignored.
- Debounce latency from a clean sw edge: 2 sync cycles plus 1–2 tick periods, plus 1 cycle to hit_valid.
- Glitch rejection: a sw pulse shorter than one tick period never reaches `stable`.
- target=0 at capture: hit_correct=0.

Optional Feature:
- Macro: MISS_CNT_EN.
- When defined:
  - Adds output miss_count [7:0].
  - Increments by 1 on every capture with hit_correct=0.
  - Saturates at 255.
  - Clears on reset and on arm rising edge.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4.
1. Reset with sw=16'h0081, then arm=1, no further change → hit_valid stays 0 for 50 cycles; no power-up event.
2. arm=1, target=16'h0020, sw[5] 0→1 held → hit_valid=1 with hit_idx=5, hit_correct=1, multi_err=0, within 2+8+1 cycles; hit_ack pulse → hit_valid=0 next cycle, state ARMED.
3. target=16'h0020, sw[3] and sw[9] toggled on the same clk → hit_idx=3, hit_correct=0, multi_err=1.
4. sw[7] 2-cycle glitch (shorter than a tick), then a valid sw[2] toggle → only report is hit_idx=2; no report for bit 7.
5. In REPORT, toggle sw[4] and drop arm before hit_ack → report unchanged until ack, then state IDLE; the sw[4] toggle is never reported, even after arm re-rises.
6. rst pulsed low mid-REPORT, asynchronous to clk → hit_valid, hit_idx, hit_correct and multi_err go to 0 immediately. With MISS_CNT_EN: 3 wrong hits → miss_count=3; arm re-rise → miss_count=0.
